// File: rtl/multicycle_control_fsm_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RV32I control FSM.
// Optional feature macro: CTRL_ZICSR_EN (CSR instructions in the SYSTEM opcode).
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_JAL      = 4'd8,
    S_JALR     = 4'd9,
    S_BRANCH   = 4'd10,
    S_AUIPC    = 4'd11,
    S_LUI      = 4'd12,
    S_ALUWB    = 4'd13,
    S_SYSTEM   = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] CAUSE_NONE    = 4'd0;
  localparam logic [3:0] CAUSE_FETCH   = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_LOAD    = 4'd5;
  localparam logic [3:0] CAUSE_STORE   = 4'd7;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP   = 2'b10;

  localparam logic [2:0] MTR_ALU = 3'b000;
  localparam logic [2:0] MTR_MEM = 3'b001;
  localparam logic [2:0] MTR_CSR = 3'b010;

  // Opcode dispatch out of DECODE; unknown opcodes go to TRAP.
  function automatic state_t dispatch(input logic [6:0] op);
    state_t s;
    case (op)
      OP_LOAD, OP_STORE: s = S_MEMADR;
      OP_R:              s = S_EXEC_R;
      OP_IMM:            s = S_EXEC_I;
      OP_JAL:            s = S_JAL;
      OP_JALR:           s = S_JALR;
      OP_BRANCH:         s = S_BRANCH;
      OP_AUIPC:          s = S_AUIPC;
      OP_LUI:            s = S_LUI;
`ifdef CTRL_ZICSR_EN
      OP_SYSTEM:         s = S_SYSTEM;
`endif
      default:           s = S_TRAP;
    endcase
    return s;
  endfunction

  // funct3 legality for opcodes that constrain it; other opcodes pass.
  function automatic logic funct3_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    case (op)
      OP_LOAD:   ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      OP_STORE:  ok = (f3 <= 3'd2);
      OP_BRANCH: ok = (f3 != 3'd2) && (f3 != 3'd3);
      OP_JALR:   ok = (f3 == 3'd0);
`ifdef CTRL_ZICSR_EN
      OP_SYSTEM: ok = (f3 != 3'd0) && (f3 != 3'd4);
`else
      OP_SYSTEM: ok = 1'b0;
`endif
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Memory handshake bundle between the control FSM and the memory port.
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic lord;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output lord, input mem_ack);
  modport slave  (input mem_req, input mem_we, input lord, output mem_ack);
endinterface

// File: rtl/multicycle_control_fsm_watchdog.sv
// ctrl_mem_watchdog: counts unacknowledged request cycles; expired is
// combinational so the FSM can leave on the last allowed wait cycle.
module ctrl_mem_watchdog #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  // Wait-cycle counter; clear has priority over counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // Fires on the MEM_TIMEOUT-th consecutive wait cycle.
  always_comb begin
    expired = en && (cnt == TMO_W'(MEM_TIMEOUT - 1));
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM with memory watchdog, funct3 checking and traps.
// Optional feature macro: CTRL_ZICSR_EN (CSR instructions retire via SYSTEM).
//
// state    | meaning
// FETCH    | request instruction at PC; ack latches IR and PC+4
// DECODE   | dispatch on opcode, precompute branch target
// MEMADR   | compute load/store address
// MEMREAD  | load request at ALUOut
// MEMWB    | write load data to register file
// MEMWRITE | store request at ALUOut
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate ALU op
// JAL      | jump to precomputed target
// JALR     | jump to rs1+imm
// BRANCH   | compare and conditionally update PC
// AUIPC    | PC + upper immediate
// LUI      | upper immediate
// ALUWB    | write ALUOut / link to register file
// SYSTEM   | CSR access write-back
// TRAP     | redirect PC to trap vector, one cycle
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  multicycle_control_fsm_if.master      mem,
  input  logic                          stall,
  input  logic [6:0]                    op,
  input  logic [2:0]                    funct3,
  output logic                          ir_write,
  output logic                          pc_write,
  output logic                          pc_write_cond,
  output logic                          reg_write,
  output logic                          is_imm,
  output logic                          csr_write,
  output logic [1:0]                    pc_src,
  output logic [1:0]                    alu_src_a,
  output logic [1:0]                    alu_src_b,
  output logic [1:0]                    alu_op,
  output logic [2:0]                    mem_to_reg,
  output logic                          trap,
  output logic [3:0]                    trap_cause,
  output logic                          retire,
  output logic [3:0]                    state_o
);

  state_t     state, state_next;
  logic [3:0] cause_next;
  logic       req_int;
  logic       lord_c;
  logic       tmo_expired;
  logic       wd_clr;

  // Request is a pure function of state, stall and reset so it drops the
  // moment reset asserts and never depends on the next-state logic.
  assign req_int = reset && (((state == S_FETCH) && !stall) ||
                             (state == S_MEMREAD) || (state == S_MEMWRITE));

  assign mem.mem_req = req_int;
  assign mem.mem_we  = req_int && (state == S_MEMWRITE);
  assign mem.lord    = lord_c;
  assign state_o     = state;

  assign wd_clr = !req_int || mem.mem_ack || (state_next != state);

  ctrl_mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (req_int && !mem.mem_ack),
    .expired (tmo_expired)
  );

  // State register and trap cause captured on entry to TRAP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      trap_cause <= CAUSE_NONE;
    end else begin
      state <= state_next;
      if ((state_next == S_TRAP) && (state != S_TRAP)) trap_cause <= cause_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next    = state;
    cause_next    = CAUSE_NONE;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    is_imm        = 1'b0;
    csr_write     = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    mem_to_reg    = MTR_ALU;
    lord_c        = 1'b0;
    trap          = 1'b0;
    retire        = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 select only matters on the completing cycle, so it is
        // qualified with the ack to keep idle outputs at zero.
        if (req_int && mem.mem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = 2'b01;
          state_next = S_DECODE;
        end else if (tmo_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b10;
        state_next = dispatch(op);
        if (!funct3_legal(op, funct3)) state_next = S_TRAP;
        if (state_next == S_TRAP) cause_next = CAUSE_ILLEGAL;
      end
      S_MEMADR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        lord_c = 1'b1;
        if (mem.mem_ack) begin
          state_next = S_MEMWB;
        end else if (tmo_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_LOAD;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = MTR_MEM;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        lord_c = 1'b1;
        if (mem.mem_ack) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (tmo_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_STORE;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b01;
        alu_op     = ALU_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        alu_op     = ALU_FUNCT;
        is_imm     = 1'b1;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = PC_SRC_ALUOUT;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        is_imm     = 1'b1;
        pc_write   = 1'b1;
        pc_src     = PC_SRC_ALU;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b01;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b10;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_SYSTEM: begin
`ifdef CTRL_ZICSR_EN
        reg_write  = 1'b1;
        mem_to_reg = MTR_CSR;
        csr_write  = 1'b1;
        retire     = 1'b1;
`endif
        state_next = S_FETCH;
      end
      S_TRAP: begin
        trap       = 1'b1;
        pc_write   = 1'b1;
        pc_src     = PC_SRC_TRAP;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven bench for multicycle_control_fsm (MEM_TIMEOUT=4).
module tb_multicycle_control_fsm;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011;
  localparam logic [6:0] T_JAL = 7'b1101111, T_BR = 7'b1100011, T_SYS = 7'b1110011;
  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
  localparam logic [3:0] XR = 4'd6, J = 4'd8, BR = 4'd10, WB = 4'd13, SY = 4'd14, TR = 4'd15;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       ir_write, pc_write, pc_write_cond, reg_write, is_imm, csr_write;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] mem_to_reg;
  logic       trap, retire;
  logic [3:0] trap_cause, state_o;

  int n_vec = 0;
  int n_bad = 0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .mem           (bus),
    .stall         (stall),
    .op            (op),
    .funct3        (funct3),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .reg_write     (reg_write),
    .is_imm        (is_imm),
    .csr_write     (csr_write),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .mem_to_reg    (mem_to_reg),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .retire        (retire),
    .state_o       (state_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       stall, ack;
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] st;
    logic       req, irw, pcw, rw, ret, trp;
    logic [3:0] cause;
    logic [1:0] pcs;
    logic       lord, we;
  } vec_t;

  vec_t vecs[$];

  function automatic void row(input logic s, input logic a, input logic [6:0] o,
                              input logic [2:0] f, input logic [3:0] st,
                              input logic req, input logic irw, input logic pcw,
                              input logic rw, input logic ret, input logic trp,
                              input logic [3:0] cause, input logic [1:0] pcs,
                              input logic lord, input logic we);
    vec_t v;
    v.stall = s; v.ack = a; v.op = o; v.f3 = f; v.st = st;
    v.req = req; v.irw = irw; v.pcw = pcw; v.rw = rw; v.ret = ret; v.trp = trp;
    v.cause = cause; v.pcs = pcs; v.lord = lord; v.we = we;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic [6:0] o, input logic [2:0] f);
    stall = s; bus.mem_ack = a; op = o; funct3 = f;
    #1;
  endtask

  initial begin
    bus.mem_ack = 1'b0;

    // ADD, zero-wait
    row(0,1,T_R,0, F ,1,1,1,0,0,0, 4'd0,2'b00,0,0);
    row(0,1,T_R,0, D ,0,0,0,0,0,0, 4'd0,2'b00,0,0);
    row(0,1,T_R,0, XR,0,0,0,0,0,0, 4'd0,2'b00,0,0);
    row(0,1,T_R,0, WB,0,0,0,1,1,0, 4'd0,2'b00,0,0);
    // LW, ack after 3 wait cycles in MEMREAD
    row(0,1,T_LOAD,2, F  ,1,1,1,0,0,0, 4'd0,2'b00,0,0);
    row(0,0,T_LOAD,2, D  ,0,0,0,0,0,0, 4'd0,2'b00,0,0);
    row(0,0,T_LOAD,2, MA ,0,0,0,0,0,0, 4'd0,2'b00,0,0);
    row(0,0,T_LOAD,2, MR ,1,0,0,0,0,0, 4'd0,2'b00,1,0);
    row(0,0,T_LOAD,2, MR ,1,0,0,0,0,0, 4'd0,2'b00,1,0);
    row(0,0,T_LOAD,2, MR ,1,0,0,0,0,0, 4'd0,2'b00,1,0);
    row(0,1,T_LOAD,2, MR ,1,0,0,0,0,0, 4'd0,2'b00,1,0);
    row(0,0,T_LOAD,2, MWB,0,0,0,1,1,0, 4'd0,2'b00,0,0);
    // SW, never acked: store fault after 4 wait cycles
    row(0,1,T_STORE,2, F ,1,1,1,0,0,0, 4'd0,2'b00,0,0);
    row(0,0,T_STORE,2, D ,0,0,0,0,0,0, 4'd0,2'b00,0,0);
    row(0,0,T_STORE,2, MA,0,0,0,0,0,0, 4'd0,2'b00,0,0);
    row(0,0,T_STORE,2, MW,1,0,0,0,0,0, 4'd0,2'b00,1,1);
    row(0,0,T_STORE,2, MW,1,0,0,0,0,0, 4'd0,2'b00,1,1);
    row(0,0,T_STORE,2, MW,1,0,0,0,0,0, 4'd0,2'b00,1,1);
    row(0,0,T_STORE,2, MW,1,0,0,0,0,0, 4'd0,2'b00,1,1);
    row(0,0,T_STORE,2, TR,0,0,1,0,0,1, 4'd7,2'b10,0,0);
    // opcode 0 is illegal
    row(0,1,7'd0,0, F ,1,1,1,0,0,0, 4'd7,2'b00,0,0);
    row(0,0,7'd0,0, D ,0,0,0,0,0,0, 4'd7,2'b00,0,0);
    row(0,0,7'd0,0, TR,0,0,1,0,0,1, 4'd2,2'b10,0,0);
    // LW with funct3=3 is illegal
    row(0,1,T_LOAD,3, F ,1,1,1,0,0,0, 4'd2,2'b00,0,0);
    row(0,0,T_LOAD,3, D ,0,0,0,0,0,0, 4'd2,2'b00,0,0);
    row(0,0,T_LOAD,3, TR,0,0,1,0,0,1, 4'd2,2'b10,0,0);
    // BEQ: three cycles, retire in BRANCH
    row(0,1,T_BR,0, F ,1,1,1,0,0,0, 4'd2,2'b00,0,0);
    row(0,0,T_BR,0, D ,0,0,0,0,0,0, 4'd2,2'b00,0,0);
    row(0,0,T_BR,0, BR,0,0,0,0,1,0, 4'd2,2'b01,0,0);
    // JAL then link write-back
    row(0,1,T_JAL,0, F ,1,1,1,0,0,0, 4'd2,2'b00,0,0);
    row(0,0,T_JAL,0, D ,0,0,0,0,0,0, 4'd2,2'b00,0,0);
    row(0,0,T_JAL,0, J ,0,0,1,0,0,0, 4'd2,2'b01,0,0);
    row(0,0,T_JAL,0, WB,0,0,0,1,1,0, 4'd2,2'b00,0,0);
    // fetch never acked: fetch fault
    row(0,0,T_R,0, F ,1,0,0,0,0,0, 4'd2,2'b00,0,0);
    row(0,0,T_R,0, F ,1,0,0,0,0,0, 4'd2,2'b00,0,0);
    row(0,0,T_R,0, F ,1,0,0,0,0,0, 4'd2,2'b00,0,0);
    row(0,0,T_R,0, F ,1,0,0,0,0,0, 4'd2,2'b00,0,0);
    row(0,0,T_R,0, TR,0,0,1,0,0,1, 4'd1,2'b10,0,0);

    // reset held: request dropped, FETCH, cause cleared
    #2;
    chk("in_reset", {28'd0, bus.mem_req, state_o}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("reset_req", {31'd0, bus.mem_req}, 32'h1);
    chk("reset_outs", {ir_write, pc_write, pc_write_cond, reg_write, is_imm, csr_write,
                       bus.mem_we, bus.lord, trap, retire, pc_src, alu_src_a, alu_src_b,
                       alu_op, mem_to_reg, trap_cause, state_o}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].ack, vecs[i].op, vecs[i].f3);
      chk($sformatf("vec%0d", i),
          {14'd0, state_o, bus.mem_req, ir_write, pc_write, reg_write, retire, trap,
           trap_cause, pc_src, bus.lord, bus.mem_we},
          {14'd0, vecs[i].st, vecs[i].req, vecs[i].irw, vecs[i].pcw, vecs[i].rw,
           vecs[i].ret, vecs[i].trp, vecs[i].cause, vecs[i].pcs, vecs[i].lord, vecs[i].we});
      @(negedge clock);
    end

    // stall 5 cycles in FETCH, then 3 plain waits: no timeout since stall cleared it
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, T_R, 0);
      chk($sformatf("stall%0d", i), {27'd0, bus.mem_req, state_o}, {27'd0, 1'b0, F});
      @(negedge clock);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, T_R, 0);
      chk($sformatf("post_stall%0d", i), {26'd0, trap, bus.mem_req, state_o}, {26'd0, 1'b0, 1'b1, F});
      @(negedge clock);
    end
    drive(0, 1, T_R, 0);
    chk("stall_fetch_ack", {30'd0, ir_write, pc_write}, 32'h3);
    @(negedge clock);
    drive(0, 0, T_R, 0);
    chk("stall_decode", {28'd0, state_o}, {28'd0, D});
    @(negedge clock);
    @(negedge clock);
    drive(0, 0, T_R, 0);
    chk("stall_aluwb", {27'd0, retire, state_o}, {27'd0, 1'b1, WB});
    @(negedge clock);

    // CSRRW
    drive(0, 1, T_SYS, 1);
    @(negedge clock);
    drive(0, 0, T_SYS, 1);
    @(negedge clock);
    drive(0, 0, T_SYS, 1);
`ifdef CTRL_ZICSR_EN
    chk("csrrw", {22'd0, state_o, csr_write, retire, reg_write, mem_to_reg, trap},
                 {22'd0, SY, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0});
`else
    chk("csrrw", {22'd0, state_o, csr_write, retire, trap, trap_cause},
                 {22'd0, TR, 1'b0, 1'b0, 1'b1, 4'd2});
`endif
    @(negedge clock);

    // reset asserted during MEMREAD
    drive(0, 1, T_LOAD, 0);
    @(negedge clock);
    drive(0, 0, T_LOAD, 0);
    @(negedge clock);
    @(negedge clock);
    drive(0, 0, T_LOAD, 0);
    chk("memread_pre", {26'd0, bus.mem_req, bus.lord, state_o}, {26'd0, 1'b1, 1'b1, MR});
    reset = 1'b0;
    #1;
    chk("memread_rst", {23'd0, bus.mem_req, trap_cause, state_o}, {23'd0, 1'b0, 4'd0, F});
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("after_rst", {27'd0, bus.mem_req, state_o}, {27'd0, 1'b1, F});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
